// File: rtl/timer_arbiter_if.sv
// Requester-side bus of timer_arbiter: request levels, per-requester counts,
// one-hot grant/completion, busy flag and current owner id.
interface timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   REQ;
    logic [NREQ*W-1:0] REQ_N;
    logic [NREQ-1:0]   GNT;
    logic [NREQ-1:0]   DONE;
    logic              BUSY;
    logic [IDW-1:0]    CUR_ID;

    modport master (
        output REQ, REQ_N,
        input  GNT, DONE, BUSY, CUR_ID
    );

    modport slave (
        input  REQ, REQ_N,
        output GNT, DONE, BUSY, CUR_ID
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one divide-by-N cycle timer among NREQ requesters.
// Define TIMER_ARB_ABORT_EN to let the owner cancel its countdown by dropping REQ.
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic           CLK,
    input  logic           RES,
    timer_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, RECOV} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    nlat_q, nlat_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  win_id;
    logic [W-1:0]    win_n;
    logic            abort;

    // Search LAST+1, LAST+2, ... wrapping; descending k lets the nearest hit win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) pick = IDW'((int'(last) + k) % NREQ);
        end
        return pick;
    endfunction

    assign win_id = rr_pick(bus.REQ, last_q);
    assign win_n  = bus.REQ_N[int'(win_id)*W +: W];

`ifdef TIMER_ARB_ABORT_EN
    assign abort = ~bus.REQ[cur_id_q];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nlat_d   = nlat_q;
        last_d   = last_q;
        cur_id_d = cur_id_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    gnt_d         = '0;
                    gnt_d[win_id] = 1'b1;
                    cur_id_d      = win_id;
                    last_d        = win_id;
                    busy_d        = 1'b1;
                    // A zero count would never match cnt, so it is treated as one cycle.
                    nlat_d        = (win_n == '0) ? W'(1) : win_n;
                    cnt_d         = W'(1);
                    state_d       = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    gnt_d   = '0;
                    state_d = RECOV;
                end else if (cnt_q == nlat_q) begin
                    gnt_d            = '0;
                    done_d[cur_id_q] = 1'b1;
                    state_d          = RECOV;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            RECOV: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nlat_q   <= '0;
            last_q   <= IDW'(NREQ - 1);
            cur_id_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nlat_q   <= nlat_d;
            last_q   <= last_d;
            cur_id_q <= cur_id_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.GNT    = gnt_q;
    assign bus.DONE   = done_q;
    assign bus.BUSY   = busy_q;
    assign bus.CUR_ID = cur_id_q;
endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one programmable divide-by-N cycle timer among several requesters.
- Each requester raises REQ with its own 8-bit count; the block grants the timer round-robin, counts N clock cycles for the winner, then pulses that requester's DONE.
- Sits between the control units and the single timer resource, so only one countdown is ever active.

Parameters:
- NREQ, 4, number of requesters (supported 2..8).
- W, 8, width of each count value (max count 2^W-1).
- IDW, 2, width of CUR_ID; must equal ceil(log2(NREQ)).

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RES  in  1  synchronous active-high reset.
- REQ  in  NREQ  per-requester request level; bit i belongs to requester i.
- REQ_N  in  NREQ*W  packed counts; requester i owns bits [i*W +: W].
- GNT  out  NREQ  one-hot grant, high while requester i owns the timer.
- DONE  out  NREQ  one-cycle completion pulse to the owning requester.
- BUSY  out  1  high from grant until end of the recovery cycle.
- CUR_ID  out  IDW  index of current or last granted requester.

Behaviour:
- Reset: all of the following are set on a posedge with RES=1, overriding any in-flight operation with no DONE pulse.
  - GNT=0, DONE=0, BUSY=0, CUR_ID=0.
  - Internal state=IDLE, count register=0, latched N=0.
  - Round-robin pointer LAST=NREQ-1, so requester 0 has first priority.
- States: IDLE, COUNT, RECOV.
- IDLE, REQ==0: stay in IDLE; outputs unchanged except DONE=0.
- IDLE, any REQ bit set:
  - Winner = first set bit searching LAST+1, LAST+2, ... wrapping mod NREQ, ending at LAST.
  - At that edge: GNT[winner]=1, CUR_ID=winner, BUSY=1, LAST=winner.
  - NLAT = REQ_N slice of winner, with 0 replaced by 1.
  - cnt=1; go to COUNT.
- COUNT:
  - If cnt==NLAT: GNT=0, DONE[CUR_ID]=1, go to RECOV.
  - Otherwise cnt=cnt+1.
  - Result: GNT is high for exactly NLAT cycles; DONE goes high at grant edge + NLAT.
- RECOV: DONE=0, BUSY=0, go to IDLE.
  - Minimum spacing between one DONE edge and the next grant edge is 2 cycles.
- Count width rules:
  - cnt and NLAT are W bits; cnt never exceeds NLAT, so no wrap.
  - N=2^W-1 is valid and gives GNT high for 255 cycles at W=8.
- REQ_N is sampled only at the grant edge; later changes are ignored.
- REQ bits of non-owners may change freely during COUNT and RECOV; they are only evaluated in IDLE.
- A requester drops REQ on the cycle after it sees DONE.
  - A REQ still high in IDLE counts as a new request and is arbitrated normally.
  - Round robin then favours other pending requesters first.
- Owner dropping REQ during COUNT is ignored (count runs to completion) unless the optional feature is enabled.
- Simultaneous requests in IDLE: exactly one grant; GNT is always one-hot or zero.
- DONE is always one-hot or zero and never coincides with GNT on the same bit.

Optional Feature:
- Macro: TIMER_ARB_ABORT_EN.
- Defined:
  - In COUNT, if REQ[CUR_ID]==0, that edge sets GNT=0 and goes to RECOV with no DONE pulse.
  - BUSY clears in RECOV as normal; LAST stays at the aborted id.
  - The abort check has priority over the cnt==NLAT check.
- Undefined: no abort path; the owner's REQ is not examined during COUNT.

Test Plan:
- Reset then REQ=0001, REQ_N[7:0]=8:
  - Grant edge gives GNT=0001, BUSY=1.
  - GNT is high for 8 cycles; DONE=0001 for 1 cycle at grant+8.
  - BUSY=0 one cycle later.
- REQ=1111 held, all counts 3 (each requester drops its REQ after its DONE):
  - Grant order is 0,1,2,3.
  - Each GNT is 3 cycles; grant-to-grant spacing is 5 cycles.
  - GNT and DONE stay one-hot throughout.
- REQ_N slice=0: behaves as N=1.
  - GNT is high for 1 cycle; DONE at grant+1.
- RES=1 asserted mid-COUNT at cnt=4 of 8:
  - Next edge: GNT=0, DONE=0, BUSY=0.
  - No DONE pulse ever follows.
  - A request then held on REQ[1] and REQ[0] is granted to requester 0 first.
- Change the owner's REQ_N from 8 to 2 after the grant: DONE still arrives at grant+8.
- With TIMER_ARB_ABORT_EN, REQ[2] dropped at cnt=3 of 10:
  - GNT=0 at the next edge and no DONE.
  - BUSY=0 one cycle later.
  - A pending REQ[3] is then granted.
  - Without the macro, the same stimulus gives DONE[2] at grant+10.
